// File: rtl/apb_master.sv
// rtl/apb_master.sv - CPU request bus to APB bridge with four decoded slave selects
module apb_master #(
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter int unsigned TIMEOUT   = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic        write,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    // Last ACCESS cycle index before a non-responding slave is abandoned.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [31:0] paddr_q, paddr_d;
    logic [31:0] pwdata_q, pwdata_d;
    logic        pwrite_q, pwrite_d;
    logic [3:0]  psel_q, psel_d;
    logic        sel_valid_q, sel_valid_d;
    logic [7:0]  cnt_q, cnt_d;

    logic        hit;
    logic [3:0]  dec_sel;
    logic        sel_ready;
    logic [31:0] sel_rdata;

    // Address decode of the incoming CPU request: 4 KiB slots above BASE_ADDR.
    always_comb begin
        hit     = (addr[31:14] == BASE_ADDR[31:14]);
        dec_sel = 4'b0000;
        if (hit) begin
            dec_sel[addr[13:12]] = 1'b1;
        end
    end

    // Pick the response of the slave latched for the current transfer only.
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        case (paddr_q[13:12])
            2'd0: begin sel_ready = PREADY0; sel_rdata = PRDATA0; end
            2'd1: begin sel_ready = PREADY1; sel_rdata = PRDATA1; end
            2'd2: begin sel_ready = PREADY2; sel_rdata = PRDATA2; end
            default: begin sel_ready = PREADY3; sel_rdata = PRDATA3; end
        endcase
    end

    // Completion decision during ACCESS: miss, slave ready, or timeout.
    always_comb begin
        ready = 1'b0;
        err   = 1'b0;
        rdata = '0;
        if (state_q == ACCESS) begin
            if (!sel_valid_q) begin
                ready = 1'b1;
                err   = 1'b1;
            end else if (sel_ready) begin
                ready = 1'b1;
                rdata = sel_rdata;
            end else if (cnt_q == CNT_LAST) begin
                ready = 1'b1;
                err   = 1'b1;
            end
        end
    end

    // Next-state logic; a new request is latched from IDLE or in the completion cycle.
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        psel_d      = psel_q;
        sel_valid_d = sel_valid_q;
        cnt_d       = cnt_q;
        case (state_q)
            IDLE: begin
                if (transfer) begin
                    paddr_d     = addr;
                    pwdata_d    = wdata;
                    pwrite_d    = write;
                    psel_d      = dec_sel;
                    sel_valid_d = hit;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                if (ready) begin
                    cnt_d = '0;
                    if (transfer) begin
                        paddr_d     = addr;
                        pwdata_d    = wdata;
                        pwrite_d    = write;
                        psel_d      = dec_sel;
                        sel_valid_d = hit;
                        state_d     = SETUP;
                    end else begin
                        psel_d      = 4'b0000;
                        sel_valid_d = 1'b0;
                        state_d     = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                psel_d      = 4'b0000;
                sel_valid_d = 1'b0;
                cnt_d       = '0;
                state_d     = IDLE;
            end
        endcase
    end

    // State and APB request registers; reset aborts any transfer in flight.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            pwrite_q    <= 1'b0;
            psel_q      <= 4'b0000;
            sel_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            pwrite_q    <= pwrite_d;
            psel_q      <= psel_d;
            sel_valid_q <= sel_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign PADDR   = paddr_q;
    assign PWDATA  = pwdata_q;
    assign PWRITE  = pwrite_q;
    assign PENABLE = (state_q == ACCESS);
    assign PSEL0   = psel_q[0];
    assign PSEL1   = psel_q[1];
    assign PSEL2   = psel_q[2];
    assign PSEL3   = psel_q[3];

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - scoreboard bench for apb_master with simple slave models
module tb_apb_master;

    logic        PCLK;
    logic        PRESET;
    logic        transfer;
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic        PWRITE;
    logic        PENABLE;
    logic        PSEL0, PSEL1, PSEL2, PSEL3;
    logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3;
    logic        PREADY0, PREADY1, PREADY2, PREADY3;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic        chk;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;

    apb_master dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .transfer(transfer), .write(write), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PENABLE(PENABLE),
        .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3),
        .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3),
        .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3)
    );

    initial begin
        PCLK = 1'b0;
        forever #5 PCLK = ~PCLK;
    end

    // Slave 0: RAM with registered PREADY (one wait state per access)
    logic [31:0] mem [0:1023];
    logic        rdy0_q;
    always @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) rdy0_q <= 1'b0;
        else         rdy0_q <= PSEL0 && PENABLE && !rdy0_q;
    end
    always @(posedge PCLK) begin
        if (PSEL0 && PENABLE && rdy0_q && PWRITE) mem[PADDR[11:2]] <= PWDATA;
    end
    assign PREADY0 = rdy0_q;
    assign PRDATA0 = mem[PADDR[11:2]];

    // Slave 1: answers in its fifth ACCESS cycle
    logic [7:0] acc1_q;
    always @(posedge PCLK or negedge PRESET) begin
        if (!PRESET)               acc1_q <= 8'd0;
        else if (PSEL1 && PENABLE) acc1_q <= acc1_q + 8'd1;
        else                       acc1_q <= 8'd0;
    end
    assign PREADY1 = PSEL1 && PENABLE && (acc1_q == 8'd4);
    assign PRDATA1 = 32'h1234_5678;

    // Slave 2 never answers; slave 3 toggles PREADY freely
    logic tog3_q;
    always @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) tog3_q <= 1'b0;
        else         tog3_q <= ~tog3_q;
    end
    assign PREADY2 = 1'b0;
    assign PRDATA2 = 32'hCAFE_0002;
    assign PREADY3 = tog3_q;
    assign PRDATA3 = 32'hBAD0_0003;

    task automatic start_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                             input logic push, input logic [31:0] er, input logic ee,
                             input logic cr);
        exp_t e;
        @(posedge PCLK); #1;
        transfer = 1'b1; write = w; addr = a; wdata = d;
        if (push) begin
            e.rdata = er; e.err = ee; e.chk = cr;
            exp_q.push_back(e);
        end
        @(posedge PCLK); #1;
        transfer = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge PCLK);
        total++;
        if ({PSEL3, PSEL2, PSEL1, PSEL0, PENABLE, PWRITE, ready, err} !== 8'h00) begin
            bad++;
            $display("FAIL reset_ctl got=%b want=00000000",
                     {PSEL3, PSEL2, PSEL1, PSEL0, PENABLE, PWRITE, ready, err});
        end
        total++;
        if ({PADDR, PWDATA, rdata} !== 96'h0) begin
            bad++;
            $display("FAIL reset_data got=%h/%h/%h want=0", PADDR, PWDATA, rdata);
        end
        @(posedge PCLK); #1;
        PRESET = 1'b1;
    endtask

    task automatic test_write_read;
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            start_req(k == 0, 32'h1000_0010, 32'hDEAD_BEEF, 1'b1,
                      (k == 0) ? 32'h0 : 32'hDEAD_BEEF, 1'b0, 1'b1);
            for (int c = 1; c <= 4; c++) begin
                @(negedge PCLK);
                total++;
                if ({PSEL3, PSEL2, PSEL1, PSEL0} !== ((c <= 3) ? 4'b0001 : 4'b0000)) begin
                    bad++;
                    $display("FAIL wr_rd_psel k=%0d c=%0d got=%b", k, c, {PSEL3, PSEL2, PSEL1, PSEL0});
                end
                total++;
                if (PENABLE !== (c == 2 || c == 3)) begin
                    bad++;
                    $display("FAIL wr_rd_penable k=%0d c=%0d got=%b", k, c, PENABLE);
                end
                total++;
                if (ready !== (c == 3)) begin
                    bad++;
                    $display("FAIL wr_rd_ready k=%0d c=%0d got=%b want=%b", k, c, ready, c == 3);
                end
                if (c <= 3) begin
                    total++;
                    if (PADDR !== 32'h1000_0010 || PWDATA !== 32'hDEAD_BEEF || PWRITE !== (k == 0)) begin
                        bad++;
                        $display("FAIL wr_rd_regs k=%0d c=%0d got=%h/%h/%b", k, c, PADDR, PWDATA, PWRITE);
                    end
                end
                if (ready === 1'b1) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL wr_rd_sb unexpected ready k=%0d", k);
                    end else begin
                        e = exp_q.pop_front();
                        if (err !== e.err || (e.chk && rdata !== e.rdata)) begin
                            bad++;
                            $display("FAIL wr_rd_resp k=%0d got=%h/%b want=%h/%b", k, rdata, err, e.rdata, e.err);
                        end
                    end
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        exp_t e;
        int   nrdy;
        nrdy = 0;
        @(posedge PCLK); #1;
        transfer = 1'b1; write = 1'b1; addr = 32'h1000_0000; wdata = 32'h1111_AAAA;
        e.rdata = 32'h0; e.err = 1'b0; e.chk = 1'b1;
        exp_q.push_back(e);
        @(posedge PCLK); #1;
        addr = 32'h1000_0004; wdata = 32'h2222_BBBB;
        exp_q.push_back(e);
        for (int c = 1; c <= 7; c++) begin
            @(negedge PCLK);
            total++;
            if (PENABLE !== (c == 2 || c == 3 || c == 5 || c == 6)) begin
                bad++;
                $display("FAIL b2b_penable c=%0d got=%b", c, PENABLE);
            end
            total++;
            if (PSEL0 !== (c <= 6)) begin
                bad++;
                $display("FAIL b2b_psel0 c=%0d got=%b", c, PSEL0);
            end
            total++;
            if (ready !== (c == 3 || c == 6)) begin
                bad++;
                $display("FAIL b2b_ready c=%0d got=%b", c, ready);
            end
            if (c >= 4 && c <= 6) begin
                total++;
                if (PADDR !== 32'h1000_0004 || PWDATA !== 32'h2222_BBBB) begin
                    bad++;
                    $display("FAIL b2b_regs c=%0d got=%h/%h want=10000004/2222bbbb", c, PADDR, PWDATA);
                end
            end
            if (ready === 1'b1) begin
                nrdy++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_sb unexpected ready c=%0d", c);
                end else begin
                    e = exp_q.pop_front();
                    if (err !== e.err || (e.chk && rdata !== e.rdata)) begin
                        bad++;
                        $display("FAIL b2b_resp c=%0d got=%h/%b want=%h/%b", c, rdata, err, e.rdata, e.err);
                    end
                end
            end
            if (c == 3) begin
                @(posedge PCLK); #1;
                transfer = 1'b0;
            end
        end
        total++;
        if (nrdy != 2) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=2", nrdy);
        end
        start_req(1'b0, 32'h1000_0004, 32'h0, 1'b1, 32'h2222_BBBB, 1'b0, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge PCLK);
            if (c == 3) begin
                total++;
                if (ready !== 1'b1 || exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL b2b_readback no ready got=%b", ready);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e.rdata || err !== e.err) begin
                        bad++;
                        $display("FAIL b2b_readback got=%h/%b want=%h/%b", rdata, err, e.rdata, e.err);
                    end
                end
            end
        end
    endtask

    task automatic test_unmapped;
        exp_t e;
        start_req(1'b0, 32'h2000_0000, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
        for (int c = 1; c <= 3; c++) begin
            @(negedge PCLK);
            total++;
            if ({PSEL3, PSEL2, PSEL1, PSEL0} !== 4'b0000) begin
                bad++;
                $display("FAIL unmap_psel c=%0d got=%b want=0000", c, {PSEL3, PSEL2, PSEL1, PSEL0});
            end
            total++;
            if (ready !== (c == 2)) begin
                bad++;
                $display("FAIL unmap_ready c=%0d got=%b want=%b", c, ready, c == 2);
            end
            if (ready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unmap_sb unexpected ready");
                end else begin
                    e = exp_q.pop_front();
                    if (err !== e.err || rdata !== e.rdata) begin
                        bad++;
                        $display("FAIL unmap_resp got=%h/%b want=%h/%b", rdata, err, e.rdata, e.err);
                    end
                end
            end
        end
    endtask

    task automatic test_timeout;
        exp_t e;
        start_req(1'b0, 32'h1000_2000, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
        for (int c = 1; c <= 18; c++) begin
            @(negedge PCLK);
            total++;
            if ({PSEL3, PSEL2, PSEL1, PSEL0} !== ((c <= 17) ? 4'b0100 : 4'b0000)) begin
                bad++;
                $display("FAIL tmo_psel c=%0d got=%b", c, {PSEL3, PSEL2, PSEL1, PSEL0});
            end
            total++;
            if (PENABLE !== (c >= 2 && c <= 17)) begin
                bad++;
                $display("FAIL tmo_penable c=%0d got=%b", c, PENABLE);
            end
            total++;
            if (ready !== (c == 17)) begin
                bad++;
                $display("FAIL tmo_ready c=%0d got=%b want=%b", c, ready, c == 17);
            end
            if (ready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL tmo_sb unexpected ready");
                end else begin
                    e = exp_q.pop_front();
                    if (err !== e.err || rdata !== e.rdata) begin
                        bad++;
                        $display("FAIL tmo_resp got=%h/%b want=%h/%b", rdata, err, e.rdata, e.err);
                    end
                end
            end
        end
    endtask

    task automatic test_wait_states;
        exp_t e;
        start_req(1'b0, 32'h1000_1000, 32'h0, 1'b1, 32'h1234_5678, 1'b0, 1'b1);
        for (int c = 1; c <= 7; c++) begin
            @(negedge PCLK);
            total++;
            if (PSEL1 !== (c <= 6) || PSEL3 !== 1'b0) begin
                bad++;
                $display("FAIL wait_psel c=%0d got=%b%b", c, PSEL3, PSEL1);
            end
            total++;
            if (ready !== (c == 6)) begin
                bad++;
                $display("FAIL wait_ready c=%0d got=%b want=%b", c, ready, c == 6);
            end
            if (ready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wait_sb unexpected ready");
                end else begin
                    e = exp_q.pop_front();
                    if (err !== e.err || rdata !== e.rdata) begin
                        bad++;
                        $display("FAIL wait_resp got=%h/%b want=%h/%b", rdata, err, e.rdata, e.err);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_in_access;
        exp_t e;
        start_req(1'b0, 32'h1000_0010, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
        @(negedge PCLK);
        @(negedge PCLK);
        total++;
        if (PSEL0 !== 1'b1 || PENABLE !== 1'b1) begin
            bad++;
            $display("FAIL rst_acc_pre got=%b%b want=11", PSEL0, PENABLE);
        end
        #2 PRESET = 1'b0;
        #1;
        total++;
        if (PSEL0 !== 1'b0 || PENABLE !== 1'b0 || ready !== 1'b0) begin
            bad++;
            $display("FAIL rst_acc_async got=%b%b%b want=000", PSEL0, PENABLE, ready);
        end
        total++;
        if (PADDR !== 32'h0) begin
            bad++;
            $display("FAIL rst_acc_paddr got=%h want=0", PADDR);
        end
        for (int c = 0; c < 2; c++) begin
            @(negedge PCLK);
            total++;
            if (ready !== 1'b0) begin
                bad++;
                $display("FAIL rst_acc_noready c=%0d got=%b", c, ready);
            end
        end
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        start_req(1'b0, 32'h1000_0010, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            @(negedge PCLK);
            total++;
            if (ready !== (c == 3)) begin
                bad++;
                $display("FAIL rst_acc_ready c=%0d got=%b want=%b", c, ready, c == 3);
            end
            if (ready === 1'b1) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL rst_acc_sb unexpected ready");
                end else begin
                    e = exp_q.pop_front();
                    if (err !== e.err || rdata !== e.rdata) begin
                        bad++;
                        $display("FAIL rst_acc_resp got=%h/%b want=%h/%b", rdata, err, e.rdata, e.err);
                    end
                end
            end
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        PRESET   = 1'b0;
        transfer = 1'b0;
        write    = 1'b0;
        addr     = 32'h0;
        wdata    = 32'h0;
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_unmapped();
        test_timeout();
        test_wait_states();
        test_reset_in_access();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
